// File: rtl/cic_dc_block.sv
// DC blocker between the CIC decimator and HalfBand1: converts offset-binary samples to
// signed, removes DC with a single-pole high-pass, and gates its output during warm-up.
module cic_dc_block #(
  parameter int unsigned DW     = 17,
  parameter int unsigned K      = 8,
  parameter int unsigned SETTLE = 64
) (
  input  logic          CLKDIVC1,
  input  logic          RST,
  input  logic          en,
  input  logic          bypass,
  input  logic          clr_sat,
  input  logic [DW-1:0] x_in,
  output logic [DW-1:0] y_out,
  output logic          y_valid,
  output logic          settled,
  output logic          sat
);

  localparam int unsigned AW = DW + K + 3;
  localparam int unsigned CW = $clog2(SETTLE + 1);
  localparam logic signed [AW-1:0] F_MAX = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] F_MIN = -F_MAX - AW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [DW-1:0]        x_prev_q, x_prev_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        y_q, y_d;
  logic                 valid_q, valid_d;
  logic                 settled_q, settled_d;
  logic                 sat_q, sat_d;

  logic signed [DW:0]   diff;
  logic signed [AW-1:0] diff_ext;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] filt_full;
  logic                 clamp_c;
  logic [DW-1:0]        filt;
  logic [DW-1:0]        bp_y;
  logic                 sat_set;

  // First difference followed by a leaky integrator with pole 1 - 2^-K.
  assign diff      = $signed({1'b0, x_in}) - $signed({1'b0, x_prev_q});
  assign diff_ext  = {{(AW - DW - 1){diff[DW]}}, diff};
  assign acc_nxt   = acc_q + (diff_ext <<< K) - (acc_q >>> K);
  assign filt_full = acc_nxt >>> K;
  assign clamp_c   = (filt_full > F_MAX) || (filt_full < F_MIN);
  assign filt      = (filt_full > F_MAX) ? F_MAX[DW-1:0] :
                     (filt_full < F_MIN) ? F_MIN[DW-1:0] : filt_full[DW-1:0];
  assign bp_y      = {~x_in[DW-1], x_in[DW-2:0]};

  always_ff @(posedge CLKDIVC1 or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      x_prev_q  <= '0;
      cnt_q     <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      settled_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      x_prev_q  <= x_prev_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      settled_q <= settled_d;
      sat_q     <= sat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    x_prev_d  = x_prev_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    settled_d = settled_q;
    sat_set   = 1'b0;
    if (en) begin
      valid_d  = 1'b1;
      x_prev_d = x_in;
      case (state_q)
        ST_IDLE: begin
          acc_d   = '0;
          cnt_d   = '0;
          y_d     = bypass ? bp_y : '0;
          state_d = ST_SETTLE;
        end
        ST_SETTLE: begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + CW'(1);
          y_d   = bypass ? bp_y : '0;
          if (cnt_q == CW'(SETTLE - 1)) begin
            state_d   = ST_RUN;
            settled_d = 1'b1;
          end
        end
        ST_RUN: begin
          acc_d   = acc_nxt;
          y_d     = bypass ? bp_y : filt;
          sat_set = !bypass && clamp_c;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // A new clamp outranks a simultaneous clear.
    sat_d = (sat_q && !clr_sat) || sat_set;
  end

  assign y_out   = y_q;
  assign y_valid = valid_q;
  assign settled = settled_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_cic_dc_block.sv
// Self-checking bench for cic_dc_block: sample-count based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations and a random phase.
module tb_cic_dc_block;

  localparam int DW     = 17;
  localparam int K      = 8;
  localparam int SETTLE = 64;
  localparam longint MAXV = (2 ** (DW - 1)) - 1;
  localparam longint MINV = -(2 ** (DW - 1));

  logic          CLKDIVC1 = 1'b0;
  logic          RST      = 1'b0;
  logic          en       = 1'b0;
  logic          bypass   = 1'b0;
  logic          clr_sat  = 1'b0;
  logic [DW-1:0] x_in     = '0;
  logic [DW-1:0] y_out;
  logic          y_valid;
  logic          settled;
  logic          sat;

  int checks = 0;
  int errors = 0;

  cic_dc_block #(.DW(DW), .K(K), .SETTLE(SETTLE)) dut (
    .CLKDIVC1 (CLKDIVC1),
    .RST      (RST),
    .en       (en),
    .bypass   (bypass),
    .clr_sat  (clr_sat),
    .x_in     (x_in),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .settled  (settled),
    .sat      (sat)
  );

  always #5 CLKDIVC1 = ~CLKDIVC1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  // Reference model: behaviour keyed on how many samples were accepted since reset.
  longint        m_n, m_xprev, m_acc, m_x, m_by, m_a, m_f, m_fc;
  logic [DW-1:0] m_y;
  bit            m_valid, m_settled, m_sat, m_set;

  initial begin
    m_n = 0; m_xprev = 0; m_acc = 0; m_y = '0;
    m_valid = 0; m_settled = 0; m_sat = 0;
    forever begin
      @(posedge CLKDIVC1);
      if (RST) begin
        m_n = 0; m_xprev = 0; m_acc = 0; m_y = '0;
        m_valid = 0; m_settled = 0; m_sat = 0;
      end else begin
        m_set = 0;
        if (en) begin
          m_x  = longint'(x_in);
          m_by = m_x - (2 ** (DW - 1));
          if (m_n == 0) begin
            m_acc = 0;
            m_y   = bypass ? DW'(m_by) : '0;
          end else begin
            m_a   = m_acc + (m_x - m_xprev) * (2 ** K) - fdiv(m_acc, 2 ** K);
            m_f   = fdiv(m_a, 2 ** K);
            m_fc  = (m_f > MAXV) ? MAXV : ((m_f < MINV) ? MINV : m_f);
            m_acc = m_a;
            if (bypass) m_y = DW'(m_by);
            else if (m_n <= SETTLE) m_y = '0;
            else begin
              m_y = DW'(m_fc);
              if (m_fc != m_f) m_set = 1;
            end
          end
          m_xprev = m_x;
          m_n++;
          m_valid = 1;
          if (m_n >= SETTLE + 1) m_settled = 1;
        end else begin
          m_valid = 0;
        end
        m_sat = (m_sat && !clr_sat) || m_set;
      end
      #1;
      chk("model y_out",   longint'(y_out),   longint'(m_y));
      chk("model y_valid", longint'(y_valid), longint'(m_valid));
      chk("model settled", longint'(settled), longint'(m_settled));
      chk("model sat",     longint'(sat),     longint'(m_sat));
    end
  end

  task automatic cyc(input bit e, input int x, input bit b, input bit c);
    @(negedge CLKDIVC1);
    RST = 1'b0; en = e; x_in = DW'(x); bypass = b; clr_sat = c;
    @(posedge CLKDIVC1);
    #2;
  endtask

  task automatic rst_pulse(input int n);
    @(negedge CLKDIVC1);
    RST = 1'b1; en = 1'b1; bypass = 1'b0; clr_sat = 1'b0;
    x_in = DW'($urandom_range(0, 131071));
    repeat (n) begin
      @(posedge CLKDIVC1);
      #2;
      chk("rst y_valid", longint'(y_valid), 0);
      chk("rst y_out",   longint'(y_out),   0);
      chk("rst settled", longint'(settled), 0);
      chk("rst sat",     longint'(sat),     0);
    end
  endtask

  initial begin
    #1 RST = 1'b1;

    // Reset with en held high, then constant input through warm-up.
    rst_pulse(10);
    cyc(1, 100000, 0, 0);
    chk("prime y_valid", longint'(y_valid), 1);
    chk("prime y_out", longint'($signed(y_out)), 0);
    for (int i = 2; i <= 70; i++) begin
      cyc(1, 100000, 0, 0);
      if (i == 64) chk("const settled@64", longint'(settled), 0);
      if (i == 65) chk("const settled@65", longint'(settled), 1);
    end
    chk("const run y_out", longint'($signed(y_out)), 0);

    // Step response in RUN.
    rst_pulse(2);
    repeat (70) cyc(1, 65536, 0, 0);
    cyc(1, 66536, 0, 0);
    chk("step y0", longint'($signed(y_out)), 1000);
    cyc(1, 66536, 0, 0);
    chk("step y1", longint'($signed(y_out)), 996);
    chk("step valid", longint'(y_valid), 1);
    cyc(1, 66536, 0, 0);
    chk("step y2", longint'($signed(y_out)), 992);

    // Saturation, sticky hold, clear, and clear colliding with a new clamp.
    rst_pulse(2);
    repeat (70) cyc(1, 0, 0, 0);
    cyc(1, 131071, 0, 0);
    chk("sat y_out", longint'($signed(y_out)), 65535);
    chk("sat set", longint'(sat), 1);
    cyc(1, 0, 0, 0);
    chk("sat fall y_out", longint'($signed(y_out)), -512);
    chk("sat hold", longint'(sat), 1);
    cyc(1, 0, 0, 1);
    chk("sat clr y_out", longint'($signed(y_out)), -510);
    chk("sat cleared", longint'(sat), 0);
    cyc(1, 131071, 0, 1);
    chk("sat collide", longint'(sat), 1);
    chk("sat collide y_out", longint'($signed(y_out)), 65535);

    // Bypass and hold.
    cyc(1, 0, 1, 1);
    chk("bypass min", longint'($signed(y_out)), -65536);
    chk("bypass sat clr", longint'(sat), 0);
    cyc(1, 131071, 1, 0);
    chk("bypass max", longint'($signed(y_out)), 65535);
    chk("bypass no sat", longint'(sat), 0);
    repeat (5) begin
      cyc(0, $urandom_range(0, 131071), 1, 0);
      chk("hold y_valid", longint'(y_valid), 0);
      chk("hold y_out", longint'($signed(y_out)), 65535);
    end

    // Reset mid-warm-up must restart the full warm-up count.
    rst_pulse(2);
    cyc(1, 5000, 0, 0);
    repeat (30) cyc(1, 5000 + $urandom_range(0, 50), 0, 0);
    rst_pulse(3);
    for (int i = 1; i <= 66; i++) begin
      cyc(1, 20000, 0, 0);
      if (i == 64) chk("resettle settled@64", longint'(settled), 0);
      if (i == 65) chk("resettle settled@65", longint'(settled), 1);
    end

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLKDIVC1);
      RST     = ($urandom_range(0, 199) == 0);
      en      = ($urandom_range(0, 3) != 0);
      bypass  = ($urandom_range(0, 6) == 0);
      clr_sat = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0)
        x_in = DW'($urandom_range(0, 131071));
      else
        x_in = x_in + DW'($urandom_range(0, 64)) - DW'(32);
    end
    @(negedge CLKDIVC1);
    RST = 1'b0; en = 1'b0;
    repeat (3) @(posedge CLKDIVC1);
    #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
